// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller sitting between a
// single-issue CPU port and a slow, strobe/mfc handshaked memory.
// Stores allocate without a fill; loads fill a full line (one word).
// All outputs are registered; cpu_ready pulses the cycle after RESP.
module dcache_ctrl #(
  parameter int LINES    = 8,
  parameter int MEMDELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [15:0] cpu_rdata,
  output logic        mem_strobe,
  output logic        mem_rnotw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IW = $clog2(LINES);

  // Index must be a clean bit slice of the address; MEMDELAY only shapes the memory model.
  if (LINES < 2 || (LINES & (LINES - 1)) != 0 || MEMDELAY < 1) begin : g_bad_param
    $error("dcache_ctrl: LINES must be a power of two >= 2 and MEMDELAY >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_WAIT, S_RESP} state_t;

  // line = {valid, dirty, addr[15:0], data[15:0]}
  logic [33:0] lines_q [LINES];

  state_t      state_q, state_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        mem_strobe_q, mem_strobe_d;
  logic        mem_rnotw_q, mem_rnotw_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  logic [IW-1:0] line_idx;
  logic [33:0]   line_rd, line_wd;
  logic          line_we, hit;

  assign line_idx = cpu_addr[IW-1:0];
  assign line_rd  = lines_q[line_idx];
  assign hit      = line_rd[33] && (line_rd[31:16] == cpu_addr);

  // Next-state, next-output and line-update decode for the miss/hit FSM.
  always_comb begin
    state_d      = state_q;
    cpu_ready_d  = (state_q == S_RESP);
    cpu_rdata_d  = cpu_rdata_q;
    mem_strobe_d = 1'b0;
    mem_rnotw_d  = 1'b1;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    line_wd      = line_rd;
    case (state_q)
      S_IDLE: begin
        // cpu_ready_q high means the previous request is still being retired.
        if (cpu_req && !cpu_ready_q) begin
          if (hit) begin
            hit_count_d = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
            state_d     = S_RESP;
            if (cpu_we) begin
              line_we = 1'b1;
              line_wd = {1'b1, 1'b1, cpu_addr, cpu_wdata};
            end else begin
              cpu_rdata_d = line_rd[15:0];
            end
          end else begin
            miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
            if (line_rd[33] && line_rd[32]) begin
              state_d      = S_WB;
              mem_strobe_d = 1'b1;
              mem_rnotw_d  = 1'b0;
              mem_addr_d   = line_rd[31:16];
              mem_wdata_d  = line_rd[15:0];
            end else if (cpu_we) begin
              line_we = 1'b1;
              line_wd = {1'b1, 1'b1, cpu_addr, cpu_wdata};
              state_d = S_RESP;
            end else begin
              state_d      = S_RD;
              mem_strobe_d = 1'b1;
              mem_addr_d   = cpu_addr;
            end
          end
        end
      end
      S_WB: begin
        // Victim is out; stores allocate directly, loads go fetch.
        if (cpu_we) begin
          line_we = 1'b1;
          line_wd = {1'b1, 1'b1, cpu_addr, cpu_wdata};
          state_d = S_RESP;
        end else begin
          state_d      = S_RD;
          mem_strobe_d = 1'b1;
          mem_addr_d   = cpu_addr;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (mem_mfc) begin
          line_we     = 1'b1;
          line_wd     = {1'b1, 1'b0, cpu_addr, mem_rdata};
          cpu_rdata_d = mem_rdata;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered outputs and line storage; reset drops any in-flight miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_strobe_q <= 1'b0;
      mem_rnotw_q  <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < LINES; i++) lines_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_strobe_q <= mem_strobe_d;
      mem_rnotw_q  <= mem_rnotw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (line_we) lines_q[line_idx] <= line_wd;
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_strobe = mem_strobe_q;
  assign mem_rnotw  = mem_rnotw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a slow-memory model: a read strobe
// seen in cycle t returns data with mem_mfc in cycle t+MEMDELAY.
module tb_dcache_ctrl;
  localparam int MEMDELAY = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready, mem_strobe, mem_rnotw;
  logic [15:0] cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;
  logic        mem_mfc;
  logic [15:0] mem_rdata;

  dcache_ctrl #(.LINES(8), .MEMDELAY(MEMDELAY)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mfc(mem_mfc), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // slow memory model
  logic [15:0] mem [0:255];
  logic        mdl_mfc = 1'b0, inj_mfc = 1'b0;
  logic [15:0] mdl_rdata = '0, rd_a = '0, wr_a = '0, wr_d = '0;
  int          cnt = 0, rd_n = 0, wr_n = 0;

  assign mem_mfc   = mdl_mfc | inj_mfc;
  assign mem_rdata = mdl_rdata;

  // Count down an outstanding read, then log/serve any strobe of this cycle.
  always @(posedge clk) begin
    mdl_mfc <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mdl_mfc   <= 1'b1;
        mdl_rdata <= mem[rd_a[7:0]];
      end
    end
    if (mem_strobe) begin
      if (mem_rnotw) begin
        rd_n <= rd_n + 1;
        rd_a <= mem_addr;
        cnt  <= MEMDELAY - 1;
      end else begin
        wr_n <= wr_n + 1;
        wr_a <= mem_addr;
        wr_d <= mem_wdata;
        mem[mem_addr[7:0]] = mem_wdata;
      end
    end
  end

  int n_chk = 0, n_err = 0;
  int tr_rd, tr_wr, lat;
  logic [15:0] rdat;
  logic seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Issue one request from an idle cycle; lat = edge index (0 = accept) where ready shows.
  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                        output int edge_n, output logic [15:0] rd);
    int r0, w0;
    r0 = rd_n; w0 = wr_n;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    edge_n = -1; rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        edge_n = i;
        rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    tr_rd = rd_n - r0; tr_wr = wr_n - w0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h18] = 16'h5678;
    mem[8'h0B] = 16'h0B0B;
    mem[8'h31] = 16'h3131;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready",  cpu_ready,  1'b0);
    chk("rst_rdata",  cpu_rdata,  16'h0);
    chk("rst_strobe", mem_strobe, 1'b0);
    chk("rst_rnotw",  mem_rnotw,  1'b1);
    chk("rst_maddr",  mem_addr,   16'h0);
    chk("rst_hits",   hit_count,  16'h0);
    chk("rst_miss",   miss_count, 16'h0);
    @(posedge clk); #1;

    // cold load miss
    do_req(1'b0, 16'h0010, 16'h0, lat, rdat);
    chk("ld_miss_lat", lat, 6);
    chk("ld_miss_data", rdat, 16'hBEEF);
    chk("ld_miss_rd", tr_rd, 1);
    chk("ld_miss_rda", rd_a, 16'h0010);
    chk("ld_miss_wr", tr_wr, 0);
    chk("ld_miss_cnt", miss_count, 16'd1);

    // load hit
    do_req(1'b0, 16'h0010, 16'h0, lat, rdat);
    chk("ld_hit_lat", lat, 1);
    chk("ld_hit_data", rdat, 16'hBEEF);
    chk("ld_hit_stb", tr_rd + tr_wr, 0);
    chk("ld_hit_cnt", hit_count, 16'd1);

    // store hit makes line dirty, then conflicting load writes it back
    do_req(1'b1, 16'h0010, 16'h1234, lat, rdat);
    chk("st_hit_lat", lat, 1);
    chk("st_hit_cnt", hit_count, 16'd2);
    do_req(1'b0, 16'h0018, 16'h0, lat, rdat);
    chk("wb_ld_lat", lat, 7);
    chk("wb_ld_data", rdat, 16'h5678);
    chk("wb_ld_wr", tr_wr, 1);
    chk("wb_ld_wra", wr_a, 16'h0010);
    chk("wb_ld_wrd", wr_d, 16'h1234);
    chk("wb_ld_rd", tr_rd, 1);
    chk("wb_ld_rda", rd_a, 16'h0018);
    chk("wb_ld_mem", mem[8'h10], 16'h1234);
    chk("wb_ld_cnt", miss_count, 16'd2);

    // store miss to clean index allocates without memory traffic
    do_req(1'b1, 16'h0003, 16'h00AA, lat, rdat);
    chk("st_miss_lat", lat, 1);
    chk("st_miss_stb", tr_rd + tr_wr, 0);
    chk("st_miss_cnt", miss_count, 16'd3);
    do_req(1'b0, 16'h0003, 16'h0, lat, rdat);
    chk("st_alloc_lat", lat, 1);
    chk("st_alloc_data", rdat, 16'h00AA);
    chk("st_alloc_hits", hit_count, 16'd3);

    // allocated store line is dirty: conflicting load writes it back
    do_req(1'b0, 16'h000B, 16'h0, lat, rdat);
    chk("wb3_lat", lat, 7);
    chk("wb3_data", rdat, 16'h0B0B);
    chk("wb3_mem", mem[8'h03], 16'h00AA);

    // store miss over clean, then store miss over dirty (write-back, no fill)
    do_req(1'b1, 16'h0020, 16'h4444, lat, rdat);
    chk("st_clean_lat", lat, 1);
    chk("st_clean_stb", tr_rd + tr_wr, 0);
    do_req(1'b1, 16'h0028, 16'h5555, lat, rdat);
    chk("st_dirty_lat", lat, 2);
    chk("st_dirty_wr", tr_wr, 1);
    chk("st_dirty_wra", wr_a, 16'h0020);
    chk("st_dirty_wrd", wr_d, 16'h4444);
    chk("st_dirty_rd", tr_rd, 0);
    chk("st_dirty_cnt", miss_count, 16'd6);

    // spurious mfc while idle is ignored
    inj_mfc = 1'b1;
    @(posedge clk); #1 inj_mfc = 1'b0;
    seen = cpu_ready;
    @(posedge clk); #1;
    seen = seen | cpu_ready;
    chk("stale_mfc_rdy", seen, 1'b0);
    do_req(1'b0, 16'h0028, 16'h0, lat, rdat);
    chk("st_dirty_hit_lat", lat, 1);
    chk("st_dirty_hit_data", rdat, 16'h5555);
    chk("st_dirty_hit_cnt", hit_count, 16'd4);

    // reset while waiting on memory; model's mfc and an injected one arrive later
    cpu_we = 1'b0; cpu_addr = 16'h0031; cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("midrst_ready",  cpu_ready,  1'b0);
    chk("midrst_strobe", mem_strobe, 1'b0);
    chk("midrst_rnotw",  mem_rnotw,  1'b1);
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inj_mfc = (i == 1);
      @(posedge clk); #1;
      seen = seen | cpu_ready | mem_strobe;
    end
    inj_mfc = 1'b0;
    chk("midrst_quiet", seen, 1'b0);
    chk("midrst_hits", hit_count, 16'd0);
    chk("midrst_miss", miss_count, 16'd0);
    do_req(1'b0, 16'h0031, 16'h0, lat, rdat);
    chk("postrst_lat", lat, 6);
    chk("postrst_data", rdat, 16'h3131);
    chk("postrst_miss", miss_count, 16'd1);

    // hit counter saturation
    force dut.hit_count_q = 16'hFFFE;
    #1 release dut.hit_count_q;
    do_req(1'b0, 16'h0031, 16'h0, lat, rdat);
    chk("sat_hit1", hit_count, 16'hFFFF);
    do_req(1'b0, 16'h0031, 16'h0, lat, rdat);
    chk("sat_hit2", hit_count, 16'hFFFF);
    do_req(1'b0, 16'h0031, 16'h0, lat, rdat);
    chk("sat_hit3", hit_count, 16'hFFFF);
    chk("sat_data", rdat, 16'h3131);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
